// File: rtl/dsram_responder_pkg.sv
// Shared encodings for the data-SRAM responder: width selects, FSM states, default base.
package dsram_responder_pkg;

  localparam logic [3:0]  SEL_B = 4'b0001;
  localparam logic [3:0]  SEL_H = 4'b0010;
  localparam logic [3:0]  SEL_W = 4'b0100;
  localparam logic [3:0]  SEL_D = 4'b1000;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic logic sel_valid(input logic [3:0] sel);
    return (sel == SEL_B) || (sel == SEL_H) || (sel == SEL_W) || (sel == SEL_D);
  endfunction

endpackage

// File: rtl/dsram_lane_mask.sv
// Byte-lane mask and data alignment for sub-dword writes (purely combinational).
module dsram_lane_mask
  import dsram_responder_pkg::*;
(
  input  logic [3:0]  sel_i,
  input  logic [2:0]  offset_i,
  input  logic [63:0] wdata_i,
  output logic [7:0]  mask_o,
  output logic [63:0] data_o
);

  logic [7:0] base_mask;

  always_comb begin
    case (sel_i)
      SEL_B:   base_mask = 8'h01;
      SEL_H:   base_mask = 8'h03;
      SEL_W:   base_mask = 8'h0F;
      SEL_D:   base_mask = 8'hFF;
      default: base_mask = '0;
    endcase
    mask_o = base_mask << offset_i;
    data_o = wdata_i << {offset_i, 3'b000};
  end

endmodule

// File: rtl/dsram_responder.sv
// Single-port 64-bit data SRAM responder with zero-fill on reset and sticky error capture.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 512,
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dsram_e,
  input  logic        dsram_we,
  input  logic [63:0] dsram_addr,
  input  logic [63:0] dsram_wdata,
  input  logic [3:0]  dsram_sel,
  output logic [63:0] dsram_rdata,
  output logic        init_done,
  output logic        err,
  output logic [63:0] err_addr,
  input  logic        err_clr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FW = $clog2(DEPTH + 1);

  state_e        state_q;
  logic [FW-1:0] fill_q;
  logic          init_done_q;
  logic          err_q, err_d;
  logic [63:0]   err_addr_q, err_addr_d;
  logic [63:0]   rdata_q, rdata_d;

  logic [63:0]   mem [DEPTH];

  logic [63:0]   offs;
  logic [2:0]    byte_off;
  logic [AW-1:0] word_idx;
  logic          in_range, misalign, acc_err, acc_ok;
  logic [7:0]    lane_mask;
  logic [63:0]   lane_data;

  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [7:0]    mem_mask;
  logic [63:0]   mem_wdata;

  dsram_lane_mask u_lane_mask (
    .sel_i    (dsram_sel),
    .offset_i (byte_off),
    .wdata_i  (dsram_wdata),
    .mask_o   (lane_mask),
    .data_o   (lane_data)
  );

  always_comb begin
    offs     = dsram_addr - BASE_ADDR;
    byte_off = dsram_addr[2:0];
    word_idx = offs[AW+2:3];
    in_range = (dsram_addr >= BASE_ADDR) && ((offs >> 3) < 64'(DEPTH));
    misalign = ((dsram_sel == SEL_H) && byte_off[0]) ||
               ((dsram_sel == SEL_W) && (byte_off[1:0] != 2'b00)) ||
               ((dsram_sel == SEL_D) && (byte_off != 3'b000));
    acc_err  = dsram_e && ((state_q == ST_INIT) || !in_range ||
                           !sel_valid(dsram_sel) || misalign);
    acc_ok   = dsram_e && !acc_err;

    // The fill sequencer owns the single write port while in INIT.
    if (state_q == ST_INIT) begin
      mem_we    = (fill_q != FW'(DEPTH));
      mem_idx   = fill_q[AW-1:0];
      mem_mask  = '1;
      mem_wdata = '0;
    end else begin
      mem_we    = acc_ok && dsram_we;
      mem_idx   = word_idx;
      mem_mask  = lane_mask;
      mem_wdata = lane_data;
    end

    rdata_d = (acc_ok && !dsram_we) ? mem[word_idx] : '0;

    // A new error outranks a simultaneous clear.
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (acc_err) begin
      err_d = 1'b1;
      if (!err_q || err_clr) err_addr_d = dsram_addr;
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (mem_mask[b]) mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      fill_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (fill_q == FW'(DEPTH)) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
          end else begin
            fill_q <= fill_q + FW'(1);
          end
        end
        ST_READY: state_q <= ST_READY;
        default:  state_q <= ST_INIT;
      endcase
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rdata_q    <= rdata_d;
    end
  end

  assign dsram_rdata = rdata_q;
  assign init_done   = init_done_q;
  assign err         = err_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: init timing, lane writes, errors, reset restart.
module tb_dsram_responder;
  import dsram_responder_pkg::*;

  localparam int unsigned DEPTH = 128;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic        clk, rst, dsram_e, dsram_we, err_clr, init_done, err;
  logic [63:0] dsram_addr, dsram_wdata, dsram_rdata, err_addr;
  logic [3:0]  dsram_sel;

  dsram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .dsram_e     (dsram_e),
    .dsram_we    (dsram_we),
    .dsram_addr  (dsram_addr),
    .dsram_wdata (dsram_wdata),
    .dsram_sel   (dsram_sel),
    .dsram_rdata (dsram_rdata),
    .init_done   (init_done),
    .err         (err),
    .err_addr    (err_addr),
    .err_clr     (err_clr)
  );

  typedef struct {
    logic        e, we, clr;
    logic [63:0] addr, wdata;
    logic [3:0]  sel;
    logic [63:0] x_rdata;
    logic        x_err;
    logic [63:0] x_ea;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic [63:0] ea;
  } exp_t;

  vec_t tbl[23];
  exp_t sb[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input logic e, input logic we, input logic clr,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [3:0] sel, input logic [63:0] xr,
                              input logic xe, input logic [63:0] xa);
    vec_t v;
    v.e = e; v.we = we; v.clr = clr; v.addr = addr; v.wdata = wdata; v.sel = sel;
    v.x_rdata = xr; v.x_err = xe; v.x_ea = xa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic idle();
    dsram_e = 1'b0; dsram_we = 1'b0; err_clr = 1'b0;
    dsram_addr = '0; dsram_wdata = '0; dsram_sel = '0;
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    exp_t x;
    dsram_e = v.e; dsram_we = v.we; err_clr = v.clr;
    dsram_addr = v.addr; dsram_wdata = v.wdata; dsram_sel = v.sel;
    x.rdata = v.x_rdata; x.err = v.x_err; x.ea = v.x_ea;
    sb.push_back(x);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk($sformatf("row%0d_scoreboard_empty", idx), 64'd0, 64'd1);
    end else begin
      x = sb.pop_front();
      chk($sformatf("row%0d_rdata", idx), dsram_rdata, x.rdata);
      chk($sformatf("row%0d_err", idx), {63'd0, err}, {63'd0, x.err});
      chk($sformatf("row%0d_err_addr", idx), err_addr, x.ea);
    end
  endtask

  task automatic wait_init(input string tag);
    for (int k = 1; k <= int'(DEPTH) + 1; k++) begin
      @(posedge clk); #1;
      if (k == int'(DEPTH)) chk({tag, "_init_done_early"}, {63'd0, init_done}, 64'd0);
      if (k == int'(DEPTH) + 1) chk({tag, "_init_done"}, {63'd0, init_done}, 64'd1);
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 64'h8000_0000, 64'h0, SEL_D, 64'h0, 0, 64'h0);
    tbl[1]  = mk(1, 1, 0, 64'h8000_0008, 64'h1122_3344_5566_7788, SEL_D, 64'h0, 0, 64'h0);
    tbl[2]  = mk(1, 1, 0, 64'h8000_000B, 64'h5555_5555_5555_55AA, SEL_B, 64'h0, 0, 64'h0);
    tbl[3]  = mk(1, 0, 0, 64'h8000_0008, 64'h0, SEL_D, 64'h1122_3344_AA66_7788, 0, 64'h0);
    tbl[4]  = mk(1, 1, 0, 64'h8000_0010, 64'hDEAD_BEEF_0000_0001, SEL_D, 64'h0, 0, 64'h0);
    tbl[5]  = mk(1, 0, 0, 64'h8000_0010, 64'h0, SEL_D, 64'hDEAD_BEEF_0000_0001, 0, 64'h0);
    tbl[6]  = mk(0, 1, 0, 64'h8000_0010, 64'h0, SEL_D, 64'h0, 0, 64'h0);
    tbl[7]  = mk(1, 0, 0, 64'h8000_0010, 64'h0, SEL_D, 64'hDEAD_BEEF_0000_0001, 0, 64'h0);
    tbl[8]  = mk(1, 1, 0, 64'h8000_0001, 64'hBEEF, SEL_H, 64'h0, 1, 64'h8000_0001);
    tbl[9]  = mk(1, 0, 0, 64'h8000_0000, 64'h0, SEL_D, 64'h0, 1, 64'h8000_0001);
    tbl[10] = mk(1, 0, 0, 64'h7FFF_FFF8, 64'h0, SEL_D, 64'h0, 1, 64'h8000_0001);
    tbl[11] = mk(1, 0, 0, 64'h8000_0400, 64'h0, SEL_D, 64'h0, 1, 64'h8000_0001);
    tbl[12] = mk(1, 1, 1, 64'h8000_0020, 64'hFFFF, 4'b0011, 64'h0, 1, 64'h8000_0020);
    tbl[13] = mk(0, 0, 1, 64'h0, 64'h0, 4'b0000, 64'h0, 0, 64'h0);
    tbl[14] = mk(1, 0, 0, 64'h8000_0020, 64'h0, SEL_D, 64'h0, 0, 64'h0);
    tbl[15] = mk(1, 1, 0, 64'h8000_0024, 64'h1234_5678_CAFE_BABE, SEL_W, 64'h0, 0, 64'h0);
    tbl[16] = mk(1, 1, 0, 64'h8000_0022, 64'h9999_1234, SEL_H, 64'h0, 0, 64'h0);
    tbl[17] = mk(1, 0, 0, 64'h8000_0020, 64'h0, SEL_D, 64'hCAFE_BABE_1234_0000, 0, 64'h0);
    tbl[18] = mk(1, 1, 0, 64'h8000_0022, 64'h0, SEL_W, 64'h0, 1, 64'h8000_0022);
    tbl[19] = mk(1, 1, 0, 64'h8000_0004, 64'h0, SEL_D, 64'h0, 1, 64'h8000_0022);
    tbl[20] = mk(1, 0, 0, 64'h8000_03F8, 64'h0, SEL_D, 64'h0, 1, 64'h8000_0022);
    tbl[21] = mk(1, 0, 0, 64'h8000_0020, 64'h0, 4'b0000, 64'h0, 1, 64'h8000_0022);
    tbl[22] = mk(1, 0, 0, 64'h8000_0020, 64'h0, SEL_D, 64'hCAFE_BABE_1234_0000, 1, 64'h8000_0022);

    idle();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset_init_done", {63'd0, init_done}, 64'd0);
    chk("reset_err", {63'd0, err}, 64'd0);
    chk("reset_err_addr", err_addr, 64'd0);
    chk("reset_rdata", dsram_rdata, 64'd0);
    @(negedge clk) rst = 1'b1;
    wait_init("first");

    foreach (tbl[i]) apply_row(tbl[i], i);
    idle();

    // Asynchronous reset from READY with err set.
    rst = 1'b0;
    #1;
    chk("rst2_init_done", {63'd0, init_done}, 64'd0);
    chk("rst2_err", {63'd0, err}, 64'd0);
    chk("rst2_err_addr", err_addr, 64'd0);
    chk("rst2_rdata", dsram_rdata, 64'd0);
    @(negedge clk) rst = 1'b1;

    // Access during INIT, then reset at fill index 100.
    for (int k = 1; k <= 100; k++) begin
      if (k == 10) begin
        dsram_e = 1'b1; dsram_addr = 64'h8000_0008; dsram_sel = SEL_D;
      end else begin
        idle();
      end
      @(posedge clk); #1;
      if (k == 10) begin
        chk("init_access_err", {63'd0, err}, 64'd1);
        chk("init_access_err_addr", err_addr, 64'h8000_0008);
        chk("init_access_rdata", dsram_rdata, 64'd0);
      end
    end
    idle();
    rst = 1'b0;
    #1;
    chk("rst3_init_done", {63'd0, init_done}, 64'd0);
    chk("rst3_err", {63'd0, err}, 64'd0);
    @(negedge clk) rst = 1'b1;
    wait_init("restart");

    apply_row(mk(1, 0, 0, 64'h8000_0008, 64'h0, SEL_D, 64'h0, 0, 64'h0), 100);
    apply_row(mk(1, 0, 0, 64'h8000_0020, 64'h0, SEL_D, 64'h0, 0, 64'h0), 101);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dsram_responder.md
DSRAM_RESPONDER -- requirements
Module: dsram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 512: number of 64-bit words held.
REQ-002 SHALL have parameter BASE_ADDR, default 64'h8000_0000: byte address of word 0.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port dsram_e, input, 1: access enable.
REQ-006 SHALL have port dsram_we, input, 1: 1 = write, 0 = read; valid only with dsram_e.
REQ-007 SHALL have port dsram_addr, input, 64: byte address.
REQ-008 SHALL have port dsram_wdata, input, 64: write data, right-justified (byte in [7:0], half in [15:0], word in [31:0]).
REQ-009 SHALL have port dsram_sel, input, 4: width select; 0001 byte, 0010 half, 0100 word, 1000 dword.
REQ-010 SHALL have port dsram_rdata, output, 64: registered read data, full aligned dword.
REQ-011 SHALL have port init_done, output, 1: memory zero-fill complete.
REQ-012 SHALL have port err, output, 1: sticky access-error flag.
REQ-013 SHALL have port err_addr, output, 64: dsram_addr of the first error since last clear.
REQ-014 SHALL have port err_clr, input, 1: clears err and err_addr.

Function
REQ-015 SHALL implement a two-state FSM, INIT and READY; reset enters INIT.
REQ-016 In INIT, SHALL write 0 to one word per cycle, index 0 to DEPTH-1, then enter READY and set init_done the cycle after the last word is written; init_done stays 1 until reset.
REQ-017 Any dsram_e in INIT SHALL be an error (REQ-022); no write, dsram_rdata = 0.
REQ-018 Index SHALL be (dsram_addr - BASE_ADDR) >> 3; byte offset SHALL be dsram_addr[2:0].
REQ-019 Write in READY SHALL update only the selected lanes: byte at offset; half at lanes offset..offset+1; word at lanes offset..offset+3; dword all lanes; the data is shifted left by offset*8.
REQ-020 Read SHALL have 1-cycle latency: dsram_rdata in cycle N+1 holds the addressed word for a read accepted in cycle N; dsram_rdata is 0 in any cycle after a non-read or an erroneous read.
REQ-021 A read in cycle N+1 of a word written in cycle N SHALL return the new data; a read and a write cannot occur in the same cycle (single port).
REQ-022 Error conditions: address below BASE_ADDR or index >= DEPTH; dsram_sel not one-hot; misalignment (half offset[0]!=0, word offset[1:0]!=0, dword offset!=0); access during INIT.
REQ-023 On error: no memory update; err set next cycle; err_addr captured only if err was 0.
REQ-024 If err_clr coincides with a new error, the new error SHALL win: err=1 and err_addr = the new address.
REQ-025 dsram_we with dsram_e=0 SHALL be ignored.

Reset
REQ-026 Asserting rst SHALL immediately force: state INIT, fill index 0, init_done 0, err 0, err_addr 0, dsram_rdata 0.
REQ-027 Reset during INIT or READY SHALL restart zero-fill from index 0; memory contents need not be reset directly.

Structure
REQ-028 Shared package/defines SHALL hold: the sel encodings (SEL_B/H/W/D), the FSM state encoding, and the default BASE_ADDR.
REQ-029 Lane-mask/shift generation SHALL be one sub-module, dsram_lane_mask (sel, offset, wdata -> 8-bit byte mask, shifted data), combinational.
REQ-030 Storage SHALL be a single-port array of DEPTH x 64 bits, inferred in the module.

Verification
REQ-031 Reset, run DEPTH+1 cycles -> init_done=1 exactly DEPTH+1 cycles after rst release; read 0x8000_0000 -> 0.
REQ-032 Dword write 0x8000_0008 = 0x1122_3344_5566_7788, then byte write 0x8000_000B = 0xAA, then read -> 0x1122_3344_AA66_7788 in the next cycle.
REQ-033 Write 0x8000_0010 = 0xDEAD_BEEF_0000_0001 then immediately read the same address -> 0xDEAD_BEEF_0000_0001.
REQ-034 Half write at 0x8000_0001 -> err=1, err_addr=0x8000_0001, memory unchanged; subsequent error at 0x7FFF_FFF8 -> err_addr stays 0x8000_0001.
REQ-035 err_clr in the same cycle as a sel=0011 write at 0x8000_0020 -> err=1, err_addr=0x8000_0020.
REQ-036 Assert rst at fill index 100 -> init_done=0, fill restarts at 0, init_done=1 DEPTH+1 cycles after release.
